video_timing_gen: RTL
=====================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 12: width of the horizontal and vertical counters and of all timing inputs.
REQ-002 SHALL have parameter COORD_W, default 11: width of pixelX and pixelY.
REQ-003 SHALL have parameters HS_POL and VS_POL, default 0: active level of hs and vs.
REQ-004 SHALL have parameters DEF_HSYNC=128, DEF_HBACK=128, DEF_HACT=800, DEF_HFRONT=32, DEF_VSYNC=4, DEF_VBACK=14, DEF_VACT=600, DEF_VFRONT=1: timing loaded at reset.
REQ-005 SHALL have ports:
- pixelClk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- enable  in  1  request to run frames.
- cfgLoad  in  1  one-cycle strobe that samples the eight cfg inputs.
- cfgHSync, cfgHBack, cfgHAct, cfgHFront, cfgVSync, cfgVBack, cfgVAct, cfgVFront  in  CNT_W each  requested timing.
- cfgErr  out  1  sticky flag: the last cfgLoad was rejected.
- hs, vs  out  1  sync outputs.
- de  out  1  active-video qualifier.
- pixelX, pixelY  out  COORD_W  active-pixel coordinates.
- frameStart, lineStart  out  1  one-cycle pulses.
- stopped  out  1  high while in IDLE.

Function
REQ-006 SHALL implement a two-state FSM (IDLE, RUN), with a frame-end stop rule.
REQ-007 IDLE->RUN SHALL occur on the first cycle with enable=1; the following cycle is frame cycle k=0.
REQ-008 RUN->IDLE SHALL occur only after the last cycle of a frame (h=hTot-1, v=vTot-1) with enable=0 on that cycle; an enable drop mid-frame SHALL let the frame complete.
REQ-009 With hTot=hSync+hBack+hAct+hFront and vTot likewise, the position at frame cycle k SHALL be h=k mod hTot, v=(k div hTot) mod vTot.
- Line order SHALL be sync, back porch, active, front porch.
REQ-010 All outputs SHALL be registered and SHALL describe position (h,v) on the cycle that position is current; there is no extra latency.
REQ-011 hs SHALL equal HS_POL iff h<hSync; vs SHALL equal VS_POL iff v<vSync.
REQ-012 de SHALL be high iff hSync+hBack<=h<hSync+hBack+hAct and vSync+vBack<=v<vSync+vBack+vAct.
REQ-013 While de=1, pixelX SHALL be h-(hSync+hBack) and pixelY SHALL be v-(vSync+vBack), truncated to COORD_W; while de=0 both SHALL be 0.
REQ-014 frameStart SHALL pulse at (0,0); lineStart SHALL pulse at every h=0.
REQ-015 In IDLE: hs=!HS_POL, vs=!VS_POL, de=0, pixelX=pixelY=0, no pulses, stopped=1; in RUN, stopped=0.
REQ-016 On cfgLoad, if all sync and active fields are nonzero and both totals fit in CNT_W bits, the values SHALL be written to a shadow set and cfgErr cleared; otherwise the shadow SHALL be unchanged and cfgErr set.
REQ-017 The shadow set SHALL become the active timing only at a frame boundary: on the IDLE->RUN transition, or on the cycle a frame wraps to (0,0).
- A mid-frame cfgLoad SHALL never alter the current frame.
REQ-018 A cfgLoad coinciding with the frame wrap SHALL take effect at the next boundary, not the current one.
REQ-019 Counter arithmetic SHALL be performed in CNT_W+1 bits for the total checks; porch fields may be 0.

Reset
REQ-020 rst SHALL force IDLE, clear counters, clear cfgErr, and load the DEF_* values into both the shadow and active sets; outputs take the REQ-015 IDLE values on the next cycle.
REQ-021 rst asserted mid-frame SHALL abort the frame immediately, with no completion.

Structure
REQ-022 A shared package SHALL hold the FSM state type and the DEF_* 800x600 timing constants.
REQ-023 One sub-module, timing_shadow_reg, SHALL hold the cfg validation, the shadow set and the boundary-apply logic.

Verification
REQ-024 The bench SHALL cover at least these directed scenarios:
- Timing 2/2/4/1 (H) and 1/1/3/1 (V), enable held -> frameStart every 54 cycles; de high 4 cycles per line on lines v=2..4; pixelX 0..3; pixelY 0..2; hs low for h=0..1.
- Drop enable at k=20 -> the frame completes through k=53; stopped=1 from the next cycle; hs and vs inactive.
- cfgLoad with cfgHAct=6 at k=10 -> the current frame keeps hTot=9; the next frameStart is followed by a period of 11*6=66 cycles.
- cfgLoad with cfgVAct=0 -> cfgErr=1 and timing unchanged; a later valid cfgLoad -> cfgErr=0.
- Assert rst at k=30 of a RUN frame -> next cycle IDLE outputs and DEF timing; re-enable -> hTot=1088 and vTot=619.

Source files
------------

// File: rtl/video_timing_gen_pkg.sv
// Shared types and 800x600 default timing for the video timing generator.
package video_timing_gen_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int NUM_FIELDS = 8;

    localparam int DEF_HSYNC  = 128;
    localparam int DEF_HBACK  = 128;
    localparam int DEF_HACT   = 800;
    localparam int DEF_HFRONT = 32;
    localparam int DEF_VSYNC  = 4;
    localparam int DEF_VBACK  = 14;
    localparam int DEF_VACT   = 600;
    localparam int DEF_VFRONT = 1;

endpackage

// File: rtl/timing_shadow_reg.sv
// Validates cfg writes into a shadow timing set and promotes it to the
// active set on frame boundaries; exports the active segment edges.
module timing_shadow_reg
    import video_timing_gen_pkg::*;
#(
    parameter int CNT_W      = 12,
    parameter int DEF_HSYNC  = video_timing_gen_pkg::DEF_HSYNC,
    parameter int DEF_HBACK  = video_timing_gen_pkg::DEF_HBACK,
    parameter int DEF_HACT   = video_timing_gen_pkg::DEF_HACT,
    parameter int DEF_HFRONT = video_timing_gen_pkg::DEF_HFRONT,
    parameter int DEF_VSYNC  = video_timing_gen_pkg::DEF_VSYNC,
    parameter int DEF_VBACK  = video_timing_gen_pkg::DEF_VBACK,
    parameter int DEF_VACT   = video_timing_gen_pkg::DEF_VACT,
    parameter int DEF_VFRONT = video_timing_gen_pkg::DEF_VFRONT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_apply,
    input  logic [CNT_W-1:0] i_cfg [NUM_FIELDS],
    output logic             o_err,
    output logic [CNT_W-1:0] o_hSyncEnd,
    output logic [CNT_W-1:0] o_hActStart,
    output logic [CNT_W-1:0] o_hActEnd,
    output logic [CNT_W-1:0] o_hTot,
    output logic [CNT_W-1:0] o_vSyncEnd,
    output logic [CNT_W-1:0] o_vActStart,
    output logic [CNT_W-1:0] o_vActEnd,
    output logic [CNT_W-1:0] o_vTot
);

    localparam logic [CNT_W-1:0] DEF_SET [NUM_FIELDS] = '{
        CNT_W'(DEF_HSYNC), CNT_W'(DEF_HBACK),
        CNT_W'(DEF_HACT),  CNT_W'(DEF_HFRONT),
        CNT_W'(DEF_VSYNC), CNT_W'(DEF_VBACK),
        CNT_W'(DEF_VACT),  CNT_W'(DEF_VFRONT)
    };

    logic [CNT_W-1:0] r_sh  [NUM_FIELDS];
    logic [CNT_W-1:0] r_act [NUM_FIELDS];
    logic             r_err;
    logic             w_ok;

    // Chained CNT_W+1 bit adds; any carry means the total overflows.
    function automatic logic sum_fits(
        input logic [CNT_W-1:0] a,
        input logic [CNT_W-1:0] b,
        input logic [CNT_W-1:0] c,
        input logic [CNT_W-1:0] d
    );
        logic [CNT_W:0] s1, s2, s3;
        s1 = {1'b0, a} + {1'b0, b};
        s2 = {1'b0, s1[CNT_W-1:0]} + {1'b0, c};
        s3 = {1'b0, s2[CNT_W-1:0]} + {1'b0, d};
        return !(s1[CNT_W] | s2[CNT_W] | s3[CNT_W]);
    endfunction

    assign w_ok = (|i_cfg[0]) && (|i_cfg[2])
               && (|i_cfg[4]) && (|i_cfg[6])
               && sum_fits(i_cfg[0], i_cfg[1], i_cfg[2], i_cfg[3])
               && sum_fits(i_cfg[4], i_cfg[5], i_cfg[6], i_cfg[7]);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sh  <= DEF_SET;
            r_act <= DEF_SET;
            r_err <= 1'b0;
        end else begin
            if (i_apply)
                r_act <= r_sh;
            if (i_load) begin
                if (w_ok) begin
                    r_sh  <= i_cfg;
                    r_err <= 1'b0;
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign o_err       = r_err;
    assign o_hSyncEnd  = r_act[0];
    assign o_hActStart = r_act[0] + r_act[1];
    assign o_hActEnd   = o_hActStart + r_act[2];
    assign o_hTot      = o_hActEnd + r_act[3];
    assign o_vSyncEnd  = r_act[4];
    assign o_vActStart = r_act[4] + r_act[5];
    assign o_vActEnd   = o_vActStart + r_act[6];
    assign o_vTot      = o_vActEnd + r_act[7];

endmodule

// File: rtl/video_timing_gen.sv
// Programmable raster timing generator: sync/de/coords registered from
// the next raster position, so outputs match the current (h,v) exactly.
module video_timing_gen
    import video_timing_gen_pkg::*;
#(
    parameter int CNT_W      = 12,
    parameter int COORD_W    = 11,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int DEF_HSYNC  = video_timing_gen_pkg::DEF_HSYNC,
    parameter int DEF_HBACK  = video_timing_gen_pkg::DEF_HBACK,
    parameter int DEF_HACT   = video_timing_gen_pkg::DEF_HACT,
    parameter int DEF_HFRONT = video_timing_gen_pkg::DEF_HFRONT,
    parameter int DEF_VSYNC  = video_timing_gen_pkg::DEF_VSYNC,
    parameter int DEF_VBACK  = video_timing_gen_pkg::DEF_VBACK,
    parameter int DEF_VACT   = video_timing_gen_pkg::DEF_VACT,
    parameter int DEF_VFRONT = video_timing_gen_pkg::DEF_VFRONT
) (
    input  logic               pixelClk,
    input  logic               rst,
    input  logic               enable,
    input  logic               cfgLoad,
    input  logic [CNT_W-1:0]   cfgHSync,
    input  logic [CNT_W-1:0]   cfgHBack,
    input  logic [CNT_W-1:0]   cfgHAct,
    input  logic [CNT_W-1:0]   cfgHFront,
    input  logic [CNT_W-1:0]   cfgVSync,
    input  logic [CNT_W-1:0]   cfgVBack,
    input  logic [CNT_W-1:0]   cfgVAct,
    input  logic [CNT_W-1:0]   cfgVFront,
    output logic               cfgErr,
    output logic               hs,
    output logic               vs,
    output logic               de,
    output logic [COORD_W-1:0] pixelX,
    output logic [COORD_W-1:0] pixelY,
    output logic               frameStart,
    output logic               lineStart,
    output logic               stopped
);

    state_t             r_state, w_stNext;
    logic [CNT_W-1:0]   r_h, r_v, w_hNext, w_vNext;
    logic [CNT_W-1:0]   w_cfg [NUM_FIELDS];
    logic [CNT_W-1:0]   w_hSyncEnd, w_hActStart, w_hActEnd, w_hTot;
    logic [CNT_W-1:0]   w_vSyncEnd, w_vActStart, w_vActEnd, w_vTot;
    logic               w_apply, w_hLast, w_vLast, w_run, w_de;
    logic               r_hs, r_vs, r_de, r_fs, r_ls;
    logic [COORD_W-1:0] r_x, r_y, w_x, w_y;

    assign w_cfg = '{cfgHSync, cfgHBack, cfgHAct, cfgHFront,
                     cfgVSync, cfgVBack, cfgVAct, cfgVFront};

    timing_shadow_reg #(
        .CNT_W     (CNT_W),
        .DEF_HSYNC (DEF_HSYNC),
        .DEF_HBACK (DEF_HBACK),
        .DEF_HACT  (DEF_HACT),
        .DEF_HFRONT(DEF_HFRONT),
        .DEF_VSYNC (DEF_VSYNC),
        .DEF_VBACK (DEF_VBACK),
        .DEF_VACT  (DEF_VACT),
        .DEF_VFRONT(DEF_VFRONT)
    ) u_shadow (
        .i_clk      (pixelClk),
        .i_rst      (rst),
        .i_load     (cfgLoad),
        .i_apply    (w_apply),
        .i_cfg      (w_cfg),
        .o_err      (cfgErr),
        .o_hSyncEnd (w_hSyncEnd),
        .o_hActStart(w_hActStart),
        .o_hActEnd  (w_hActEnd),
        .o_hTot     (w_hTot),
        .o_vSyncEnd (w_vSyncEnd),
        .o_vActStart(w_vActStart),
        .o_vActEnd  (w_vActEnd),
        .o_vTot     (w_vTot)
    );

    assign w_hLast = (r_h == w_hTot - CNT_W'(1));
    assign w_vLast = (r_v == w_vTot - CNT_W'(1));

    always_comb begin
        w_stNext = r_state;
        w_hNext  = r_h;
        w_vNext  = r_v;
        w_apply  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_stNext = ST_RUN;
                    w_hNext  = '0;
                    w_vNext  = '0;
                    w_apply  = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_hLast) begin
                    w_hNext = '0;
                    if (w_vLast) begin
                        w_vNext = '0;
                        if (enable)
                            w_apply = 1'b1;
                        else
                            w_stNext = ST_IDLE;
                    end else begin
                        w_vNext = r_v + CNT_W'(1);
                    end
                end else begin
                    w_hNext = r_h + CNT_W'(1);
                end
            end
        endcase
    end

    // At (0,0) the outputs do not depend on the timing being applied,
    // since sync widths are never zero; the old active set is safe here.
    assign w_run = (w_stNext == ST_RUN);
    assign w_de  = w_run
                && (w_hNext >= w_hActStart) && (w_hNext < w_hActEnd)
                && (w_vNext >= w_vActStart) && (w_vNext < w_vActEnd);
    assign w_x   = w_de ? COORD_W'(w_hNext - w_hActStart) : '0;
    assign w_y   = w_de ? COORD_W'(w_vNext - w_vActStart) : '0;

    always_ff @(posedge pixelClk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_h     <= '0;
            r_v     <= '0;
            r_hs    <= !HS_POL;
            r_vs    <= !VS_POL;
            r_de    <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_fs    <= 1'b0;
            r_ls    <= 1'b0;
        end else begin
            r_state <= w_stNext;
            r_h     <= w_hNext;
            r_v     <= w_vNext;
            r_hs    <= (w_run && w_hNext < w_hSyncEnd) ? HS_POL : !HS_POL;
            r_vs    <= (w_run && w_vNext < w_vSyncEnd) ? VS_POL : !VS_POL;
            r_de    <= w_de;
            r_x     <= w_x;
            r_y     <= w_y;
            r_fs    <= w_run && (w_hNext == '0) && (w_vNext == '0);
            r_ls    <= w_run && (w_hNext == '0);
        end
    end

    assign hs         = r_hs;
    assign vs         = r_vs;
    assign de         = r_de;
    assign pixelX     = r_x;
    assign pixelY     = r_y;
    assign frameStart = r_fs;
    assign lineStart  = r_ls;
    assign stopped    = (r_state == ST_IDLE);

endmodule
